// File: rtl/mips150_muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer: radix-2 shift-add multiplier and
// restoring divider, one iteration per clock, with a pipeline stall request.
`timescale 1ns/1ps
module mips150_muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hilo_access,
  input  logic            mt_hi,
  input  logic            mt_lo,
  output logic            busy,
  output logic            done,
  output logic            stall_req,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic            done_q;
  logic [XLEN-1:0] hi_q, lo_q;

  logic            op_div_q, neg_q_q, neg_r_q, div0_q;
  logic [XLEN-1:0] m_q, acc_r_q, acc_q_q, rs_q;

  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0] mag_a, mag_b, fix_hi, fix_lo;
  logic [2*XLEN-1:0] prod;

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic sgn);
    return (sgn && v < 0) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  always_comb begin
    mag_a    = mag(rs_val, ~op[0]);
    mag_b    = mag(rt_val, ~op[0]);
    mul_sum  = {1'b0, acc_r_q} + (acc_q_q[0] ? {1'b0, m_q} : '0);
    rem_sh   = {acc_r_q, acc_q_q[XLEN-1]};
    // R < divisor holds between steps, so the top bit of the difference is the trial sign.
    rem_diff = rem_sh - {1'b0, m_q};
    prod     = neg_2x({acc_r_q, acc_q_q}, neg_q_q);
    if (!op_div_q) begin
      fix_hi = prod[2*XLEN-1:XLEN];
      fix_lo = prod[XLEN-1:0];
    end else if (div0_q) begin
      fix_hi = rs_q;
      fix_lo = '1;
    end else begin
      fix_hi = neg_x(acc_r_q, neg_r_q);
      fix_lo = neg_x(acc_q_q, neg_q_q);
    end
  end

  // Datapath: operand capture at start, one iteration per RUN cycle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      op_div_q <= op[1];
      neg_q_q  <= ~op[0] & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
      neg_r_q  <= ~op[0] & rs_val[XLEN-1];
      div0_q   <= (rt_val == '0);
      rs_q     <= rs_val;
      m_q      <= op[1] ? mag_b : mag_a;
      acc_q_q  <= op[1] ? mag_a : mag_b;
      acc_r_q  <= '0;
    end else if (state_q == RUN) begin
      if (!op_div_q) begin
        acc_r_q <= mul_sum[XLEN:1];
        acc_q_q <= {mul_sum[0], acc_q_q[XLEN-1:1]};
      end else if (!rem_diff[XLEN]) begin
        acc_r_q <= rem_diff[XLEN-1:0];
        acc_q_q <= {acc_q_q[XLEN-2:0], 1'b1};
      end else begin
        acc_r_q <= rem_sh[XLEN-1:0];
        acc_q_q <= {acc_q_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Control FSM with registered HI/LO and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            count_q <= CW'(XLEN - 1);
          end else if (hilo_access) begin
            if (mt_hi) hi_q <= rs_val;
            if (mt_lo) lo_q <= rs_val;
          end
        end
        RUN: begin
          count_q <= count_q - CW'(1);
          if (count_q == '0) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = busy & (start | hilo_access);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mips150_muldiv_ctrl.sv
// Bench for mips150_muldiv_ctrl: vector table and random ops checked through a
// result scoreboard, plus hand sequences for latency, stalls, MTHI/MTLO and reset.
`timescale 1ns/1ps
module tb_mips150_muldiv_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n, start, hilo_access, mt_hi, mt_lo;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val, rt_val;
  logic            busy, done, stall_req;
  logic [XLEN-1:0] hi, lo;

  always #5 clk = ~clk;

  mips150_muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hilo_access(hilo_access),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .busy(busy), .done(done),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[13];
  logic [63:0] sb_q[$];
  logic [63:0] exp_mon;
  int          n_checks = 0;
  int          n_fail = 0;
  int          dones_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (o == 2'd0) return sa * sb;
    if (o == 2'd1) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (o == 2'd2) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding result.
  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      dones_seen++;
      if (sb_q.size() == 0) begin
        check("done_unexpected", done, 1'b0);
      end else begin
        exp_mon = sb_q.pop_front();
        check("result_hilo", {hi, lo}, exp_mon);
        check("idle_after_done", busy, 1'b0);
      end
    end
  end

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check(name, got, 1'b1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    sb_q.push_back(expv);
    step();
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    wait_done("op_done_timeout");
  endtask

  initial begin
    int          busy_n, done_k, drop_k, seen0;
    logic        drop_done;
    logic [31:0] ra, rb, lo_before;
    logic [1:0]  ro;

    vecs[0]  = '{2'd0, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5]  = '{2'd1, 32'd3,        32'd5,        32'h00000000, 32'd15};
    vecs[6]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{2'd0, 32'd5,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC};
    vecs[10] = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[11] = '{2'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    vecs[12] = '{2'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};

    rst_n = 1'b0; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
    hilo_access = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    repeat (2) step();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_stall", stall_req, 1'b0);
    check("reset_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(255)) : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb));
    end

    // Latency: done high in the cycle after edge XLEN+1, busy for XLEN+1 cycles.
    start = 1'b1; op = 2'd1; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
    sb_q.push_back(64'hFFFFFFFE_00000001);
    step();
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    done_k = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (busy) busy_n++;
      if (done && done_k < 0) done_k = k;
    end
    check("done_latency", done_k, 33);
    check("busy_cycles", busy_n, 33);

    // MFLO presented mid-operation stalls until the first IDLE cycle.
    start = 1'b1; op = 2'd1; rs_val = 32'd6; rt_val = 32'd7;
    sb_q.push_back(64'd42);
    step();
    start = 1'b0;
    repeat (4) step();
    hilo_access = 1'b1;
    #1;
    check("mflo_stall_asserted", stall_req, 1'b1);
    drop_k = -1; drop_done = 1'b0;
    for (int k = 5; k <= 45; k++) begin
      step();
      if (!stall_req) begin
        drop_k = k;
        drop_done = done;
        break;
      end
    end
    hilo_access = 1'b0;
    check("mflo_stall_release", drop_k, 33);
    check("mflo_release_with_done", drop_done, 1'b1);

    // Second start while busy is held and accepted on the first IDLE cycle.
    start = 1'b1; op = 2'd3; rs_val = 32'd100; rt_val = 32'd7;
    sb_q.push_back({32'd2, 32'd14});
    step();
    start = 1'b0;
    repeat (2) step();
    start = 1'b1; op = 2'd1; rs_val = 32'd9; rt_val = 32'd9;
    #1;
    check("second_start_stall", stall_req, 1'b1);
    drop_k = -1;
    for (int k = 3; k <= 45; k++) begin
      step();
      if (!stall_req) begin
        drop_k = k;
        break;
      end
    end
    check("second_start_release", drop_k, 33);
    sb_q.push_back(64'd81);
    step();
    start = 1'b0;
    check("second_op_accepted", busy, 1'b1);
    wait_done("second_op_done_timeout");

    // MTHI / MTLO in IDLE.
    hilo_access = 1'b1; mt_hi = 1'b1; rs_val = 32'h1234;
    #1;
    check("idle_access_no_stall", stall_req, 1'b0);
    step();
    mt_hi = 1'b0; mt_lo = 1'b1; rs_val = 32'hABCD;
    check("mthi_write", hi, 32'h1234);
    step();
    hilo_access = 1'b0; mt_lo = 1'b0;
    check("mtlo_write", lo, 32'hABCD);

    // MTLO while busy is ignored and stalls.
    lo_before = lo;
    start = 1'b1; op = 2'd1; rs_val = 32'd2; rt_val = 32'd3;
    sb_q.push_back(64'd6);
    step();
    start = 1'b0; hilo_access = 1'b1; mt_lo = 1'b1; rs_val = 32'hDEAD;
    #1;
    check("mtlo_busy_stall", stall_req, 1'b1);
    repeat (3) step();
    check("mtlo_busy_ignored", lo, lo_before);
    hilo_access = 1'b0; mt_lo = 1'b0;
    wait_done("mtlo_busy_done_timeout");

    // Reset mid-RUN aborts with no result and no later done.
    start = 1'b1; op = 2'd1; rs_val = 32'd3; rt_val = 32'd5;
    sb_q.push_back(64'd15);
    step();
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hilo", {hi, lo}, 64'h0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    seen0 = dones_seen;
    repeat (40) step();
    check("abort_no_done", dones_seen, seen0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
